// File: rtl/cdc_pkg.sv
// Shared types and helpers for the input conditioning blocks.
package cdc_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    QUAL_HI,
    STABLE_HI,
    QUAL_LO
  } debounce_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Plain flip-flop synchroniser chain; unreset so it can sit on any async input.
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain = '0;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_debounce.sv
// Synchronise and debounce an asynchronous level; emit edge strobes and a
// saturating count of aborted qualifications.
//
// state     | meaning
// STABLE_LO | level is 0, synchronised input agrees
// QUAL_HI   | level is 0, counting consecutive 1 samples
// STABLE_HI | level is 1, synchronised input agrees
// QUAL_LO   | level is 1, counting consecutive 0 samples
module cdc_debounce
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0,
  parameter int GLITCH_W        = 16
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                i,
  input  logic                clr_glitch,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam debounce_state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic                s;
  debounce_state_t     state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                level_nx, rise_nx, fall_nx, glitch_inc;
  logic [GLITCH_W-1:0] glitch_nx;

  cdc_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .d   (i),
    .q   (s)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    level_nx   = level;
    rise_nx    = 1'b0;
    fall_nx    = 1'b0;
    glitch_inc = 1'b0;

    case (state)
      STABLE_LO: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = STABLE_HI;
            level_nx = 1'b1;
            rise_nx  = 1'b1;
          end else begin
            state_nx = QUAL_HI;
            cnt_nx   = CW'(1);
          end
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_nx   = STABLE_LO;
          cnt_nx     = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
          level_nx = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = STABLE_LO;
            level_nx = 1'b0;
            fall_nx  = 1'b1;
          end else begin
            state_nx = QUAL_LO;
            cnt_nx   = CW'(1);
          end
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_nx   = STABLE_HI;
          cnt_nx     = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          level_nx = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = RESET_STATE;
        cnt_nx   = '0;
      end
    endcase

    // Clear wins over a same-cycle increment; increment holds at all-ones.
    if (clr_glitch)
      glitch_nx = '0;
    else if (glitch_inc && (glitch_count != '1))
      glitch_nx = glitch_count + 1'b1;
    else
      glitch_nx = glitch_count;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= RESET_STATE;
      cnt          <= '0;
      level        <= RESET_LEVEL;
      rise         <= 1'b0;
      fall         <= 1'b0;
      glitch_count <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      level        <= level_nx;
      rise         <= rise_nx;
      fall         <= fall_nx;
      glitch_count <= glitch_nx;
    end
  end

endmodule

// File: tb/tb_cdc_debounce.sv
// Bench for cdc_debounce: two configurations driven by directed and random
// stimulus, compared every cycle against a run-length reference model.
module tb_cdc_debounce;

  localparam int D_A = 4, S_A = 2, GW_A = 3;
  localparam int D_B = 1, S_B = 2, GW_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] i_v, rst_v, clr_v;
  logic level_a, rise_a, fall_a, level_b, rise_b, fall_b;
  logic [GW_A-1:0] gc_a;
  logic [GW_B-1:0] gc_b;

  cdc_debounce #(.SYNC_STAGES(S_A), .DEBOUNCE_CYCLES(D_A), .RESET_LEVEL(1'b0), .GLITCH_W(GW_A)) dut_a (
    .clk(clk), .areset(rst_v[0]), .i(i_v[0]), .clr_glitch(clr_v[0]),
    .level(level_a), .rise(rise_a), .fall(fall_a), .glitch_count(gc_a));

  cdc_debounce #(.SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B), .RESET_LEVEL(1'b1), .GLITCH_W(GW_B)) dut_b (
    .clk(clk), .areset(rst_v[1]), .i(i_v[1]), .clr_glitch(clr_v[1]),
    .level(level_b), .rise(rise_b), .fall(fall_b), .glitch_count(gc_b));

  // Reference model: synchroniser as an i-history, filter as a run length
  // of samples disagreeing with the current level.
  int d_p[2]  = '{D_A, D_B};
  int s_p[2]  = '{S_A, S_B};
  int rl_p[2] = '{0, 1};
  int gmax[2] = '{(1 << GW_A) - 1, (1 << GW_B) - 1};
  bit hist[2][8];
  int m_lvl[2], m_run[2], m_gl[2], m_rise[2], m_fall[2];
  int rise_cnt[2], fall_cnt[2];
  int n_chk = 0, n_pass = 0;

  function automatic int o_lvl(input int k);  return (k == 0) ? int'(level_a) : int'(level_b); endfunction
  function automatic int o_rise(input int k); return (k == 0) ? int'(rise_a)  : int'(rise_b);  endfunction
  function automatic int o_fall(input int k); return (k == 0) ? int'(fall_a)  : int'(fall_b);  endfunction
  function automatic int o_gc(input int k);   return (k == 0) ? int'(gc_a)    : int'(gc_b);    endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset(input int k);
    m_lvl[k] = rl_p[k]; m_run[k] = 0; m_gl[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
  endtask

  task automatic model_edge(input int k);
    int sval;
    bit inc;
    sval = int'(hist[k][s_p[k]-1]);
    for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
    hist[k][0] = i_v[k];
    m_rise[k] = 0; m_fall[k] = 0; inc = 1'b0;
    if (rst_v[k]) begin
      model_reset(k);
    end else begin
      if (sval != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == d_p[k]) begin
          m_lvl[k] = sval;
          m_run[k] = 0;
          if (sval == 1) m_rise[k] = 1; else m_fall[k] = 1;
        end
      end else begin
        inc = (m_run[k] > 0);
        m_run[k] = 0;
      end
      if (clr_v[k]) m_gl[k] = 0;
      else if (inc && m_gl[k] < gmax[k]) m_gl[k]++;
    end
  endtask

  task automatic check_outputs(input int k);
    chk($sformatf("level%0d", k), o_lvl(k), m_lvl[k]);
    chk($sformatf("rise%0d", k), o_rise(k), m_rise[k]);
    chk($sformatf("fall%0d", k), o_fall(k), m_fall[k]);
    chk($sformatf("glitch%0d", k), o_gc(k), m_gl[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_outputs(k);
      rise_cnt[k] += o_rise(k);
      fall_cnt[k] += o_fall(k);
    end
  endtask

  task automatic set_reset(input int k, input bit v);
    rst_v[k] = v;
    if (v) begin
      model_reset(k);
      #1;
      check_outputs(k);
    end
  endtask

  task automatic wait_strobe(input int k, input bit want_rise, input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if ((want_rise ? o_rise(k) : o_fall(k)) == 1) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n, base;
    i_v = 2'b10; clr_v = 2'b00; rst_v = 2'b11;
    model_reset(0); model_reset(1);
    repeat (4) tick();
    chk("rst_level_a", o_lvl(0), 0);
    chk("rst_level_b", o_lvl(1), 1);
    chk("rst_gc_a", o_gc(0), 0);
    chk("rst_gc_b", o_gc(1), 0);
    rst_v = 2'b00;
    repeat (3) tick();

    // clean rise and fall
    i_v[0] = 1'b1;
    wait_strobe(0, 1'b1, 20, n);
    chk("rise_latency_ok", int'(n >= 5 && n <= 7), 1);
    repeat (8) tick();
    chk("rise_once", rise_cnt[0], 1);
    chk("level_held_hi", o_lvl(0), 1);
    i_v[0] = 1'b0;
    wait_strobe(0, 1'b0, 20, n);
    chk("fall_latency_ok", int'(n >= 5 && n <= 7), 1);
    repeat (8) tick();

    // five 3-cycle glitches
    base = rise_cnt[0] + fall_cnt[0];
    for (int p = 0; p < 5; p++) begin
      i_v[0] = 1'b1; repeat (3) tick();
      i_v[0] = 1'b0; repeat (10) tick();
    end
    chk("glitch5_count", o_gc(0), 5);
    chk("glitch5_strobes", rise_cnt[0] + fall_cnt[0] - base, 0);
    chk("glitch5_level", o_lvl(0), 0);

    // bounce then settle
    clr_v[0] = 1'b1; tick(); clr_v[0] = 1'b0;
    chk("clr_gc", o_gc(0), 0);
    base = rise_cnt[0];
    for (int p = 0; p < 4; p++) begin
      i_v[0] = (p % 2 == 0); repeat (2) tick();
    end
    i_v[0] = 1'b1; repeat (12) tick();
    chk("bounce_gc", o_gc(0), 2);
    chk("bounce_rises", rise_cnt[0] - base, 1);
    chk("bounce_level", o_lvl(0), 1);
    i_v[0] = 1'b0; repeat (12) tick();

    // saturation, then clear coincident with an increment
    clr_v[0] = 1'b1; tick(); clr_v[0] = 1'b0;
    for (int p = 0; p < 10; p++) begin
      i_v[0] = 1'b1; repeat (2) tick();
      i_v[0] = 1'b0; repeat (4) tick();
    end
    chk("sat_gc", o_gc(0), 7);
    i_v[0] = 1'b1; repeat (2) tick();
    i_v[0] = 1'b0; tick(); tick();
    clr_v[0] = 1'b1; tick(); clr_v[0] = 1'b0;
    chk("clr_beats_inc", o_gc(0), 0);
    repeat (4) tick();

    // reset two samples into a qualification
    i_v[0] = 1'b1; repeat (4) tick();
    base = rise_cnt[0];
    set_reset(0, 1'b1);
    chk("midq_rst_level", o_lvl(0), 0);
    repeat (2) tick();
    set_reset(0, 1'b0);
    chk("midq_no_strobe", rise_cnt[0] - base, 0);
    repeat (12) tick();
    chk("midq_requal_rise", rise_cnt[0] - base, 1);
    chk("midq_level", o_lvl(0), 1);
    chk("midq_gc", o_gc(0), 0);
    i_v[0] = 1'b0; repeat (12) tick();

    // passthrough configuration with reset level 1
    i_v[1] = 1'b0;
    wait_strobe(1, 1'b0, 10, n);
    chk("pass_fall_latency", n, S_B + 1);
    i_v[1] = 1'b1;
    wait_strobe(1, 1'b1, 10, n);
    chk("pass_rise_latency", n, S_B + 1);
    chk("pass_gc", o_gc(1), 0);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(3) == 0) i_v[k] = ~i_v[k];
        clr_v[k] = ($urandom_range(31) == 0);
        if (rst_v[k]) set_reset(k, 1'b0);
        else if ($urandom_range(499) == 0) set_reset(k, 1'b1);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
